// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM sequencing fetch, decode,
// execute, memory and write-back over a shared ALU and a single memory port.
// Memory waits are bounded by a TIMEOUT_W-bit counter; illegal instructions and
// bus timeouts park the FSM in a sticky TRAP state until reset.
// Optional feature: define MC_CTRL_JUMP_EN to decode J (opcode 000010) through a
// JUMP state; without it J traps as illegal and pc_src[1] stays 0.
module mips_multicycle_control #(
   parameter int unsigned TIMEOUT_W = 4,
   parameter int unsigned ALU_OP_W  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          opcode,
   input  logic [5:0]          func,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                mem_req,
   output logic                mem_we,
   output logic                i_or_d,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                mem_to_reg,
   output logic                trap,
   output logic [1:0]          trap_cause
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
   // Last count value before all-ones; a low mem_ready here is the final allowed wait.
   localparam logic [TIMEOUT_W-1:0] WAIT_LAST = ~TIMEOUT_W'(1);

   typedef enum logic [2:0] {
      FETCH, DECODE, EXEC, MEMACC, WB, BRANCH, JUMP, TRAP
   } ctrlState;

   ctrlState             state;
   ctrlState             nextState;
   logic [TIMEOUT_W-1:0] waitCnt;
   logic [1:0]           nextCause;
   logic                 isRType, isLw, isSw, isAddi, isBeq;
   logic                 funcLegal, execLegal, memWait, timeoutHit;
   logic [2:0]           rAluOp;
   logic [2:0]           aluOpBase;
`ifdef MC_CTRL_JUMP_EN
   logic                 isJump;
   assign isJump = (opcode == 6'b000010);
`endif

   assign isRType    = (opcode == OP_RTYPE);
   assign isLw       = (opcode == OP_LW);
   assign isSw       = (opcode == OP_SW);
   assign isAddi     = (opcode == OP_ADDI) || (opcode == OP_ADDIU);
   assign isBeq      = (opcode == OP_BEQ);
   assign execLegal  = (isRType && funcLegal) || isLw || isSw || isAddi;
   assign memWait    = (state == FETCH) || (state == MEMACC);
   assign timeoutHit = memWait && !mem_ready && (waitCnt == WAIT_LAST);
   assign alu_op     = ALU_OP_W'(aluOpBase);

   // R-type function legality and ALU operation mapping
   always_comb begin
      funcLegal = 1'b1;
      rAluOp    = 3'b000;
      case (func)
         6'b100000, 6'b100001: rAluOp = 3'b000;
         6'b100010, 6'b100011: rAluOp = 3'b001;
         6'b100100:            rAluOp = 3'b010;
         6'b100101:            rAluOp = 3'b011;
         6'b000000:            rAluOp = 3'b100;
         6'b000010:            rAluOp = 3'b101;
         6'b101010:            rAluOp = 3'b110;
         6'b101011:            rAluOp = 3'b111;
         default:              funcLegal = 1'b0;
      endcase
   end

   // Next-state selection and trap cause for the transition into TRAP
   always_comb begin
      nextState = state;
      nextCause = 2'b00;
      case (state)
         FETCH: begin
            if (mem_ready) begin
               nextState = DECODE;
            end else if (timeoutHit) begin
               nextState = TRAP;
               nextCause = CAUSE_TIMEOUT;
            end
         end
         DECODE: begin
            if (execLegal) begin
               nextState = EXEC;
            end else if (isBeq) begin
               nextState = BRANCH;
`ifdef MC_CTRL_JUMP_EN
            end else if (isJump) begin
               nextState = JUMP;
`endif
            end else begin
               nextState = TRAP;
               nextCause = CAUSE_ILLEGAL;
            end
         end
         EXEC:   nextState = (isLw || isSw) ? MEMACC : WB;
         MEMACC: begin
            if (mem_ready) begin
               nextState = isSw ? FETCH : WB;
            end else if (timeoutHit) begin
               nextState = TRAP;
               nextCause = CAUSE_TIMEOUT;
            end
         end
         WB, BRANCH, JUMP: nextState = FETCH;
         TRAP:    nextState = TRAP;
         default: nextState = FETCH;
      endcase
   end

   // State register, memory wait counter and sticky trap flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         waitCnt    <= '0;
         trap       <= 1'b0;
         trap_cause <= 2'b00;
      end else begin
         state <= nextState;
         if (memWait && (nextState == state)) begin
            waitCnt <= waitCnt + TIMEOUT_W'(1);
         end else begin
            waitCnt <= '0;
         end
         if ((nextState == TRAP) && (state != TRAP)) begin
            trap       <= 1'b1;
            trap_cause <= nextCause;
         end
      end
   end

   // Datapath controls decoded from the current state and instruction fields
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      aluOpBase  = 3'b000;
      reg_dst    = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      case (state)
         FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         DECODE: alu_src_b = 2'b11;
         EXEC: begin
            alu_src_a = 1'b1;
            if (isRType) begin
               aluOpBase = rAluOp;
            end else begin
               alu_src_b = 2'b10;
            end
         end
         MEMACC: begin
            mem_req = 1'b1;
            i_or_d  = 1'b1;
            mem_we  = isSw;
         end
         WB: begin
            reg_write  = 1'b1;
            reg_dst    = isRType;
            mem_to_reg = isLw;
         end
         BRANCH: begin
            alu_src_a = 1'b1;
            aluOpBase = 3'b001;
            pc_src    = 2'b01;
            pc_write  = zero;
         end
`ifdef MC_CTRL_JUMP_EN
         JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
`endif
         default: ;
      endcase
   end

endmodule
